ctrl_fsm: RTL

//  Multi-cycle sequencing control unit for the accumulator CPU; successor to the pure opcode decoder.
//  - Sequences FETCH/DECODE/EXEC/MEM/IO and handshakes with memory and I/O.
//  - Generates PC, IR, ACC and flag strobes, and qualifies BRC/BRZ on the flags.
//  - Sits between IR/flag registers and datapath, memory and I/O ports.

---
 rtl/ctrl_fsm.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ctrl_fsm.sv
// Multi-cycle sequencing control unit for the accumulator CPU (FETCH/DECODE/EXEC/MEM/IO).
// Optional retire counter output enabled by defining CTRL_RETIRE_CNT_EN.
module ctrl_fsm #(
  parameter int unsigned OP_W  = 4
`ifdef CTRL_RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            carry_i,
  input  logic            zero_i,
  input  logic            mem_ack_i,
  input  logic            inp_valid_i,
  input  logic            out_ready_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            ir_load_o,
  output logic            pc_inc_o,
  output logic            pc_load_o,
  output logic            acc_load_o,
  output logic            flags_load_o,
  output logic            imm_o,
  output logic            mr_o,
  output logic            mw_o,
  output logic            inp_o,
  output logic            out_o,
  output logic            jmp_o,
  output logic            alu_o,
  output logic            ill_o,
  output logic [2:0]      state_o
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_IO     = 3'd4
  } state_e;

  // brc/brz refine the jmp class so EXEC knows which flag qualifies the branch
  typedef struct packed {
    logic imm;
    logic mr;
    logic mw;
    logic inp;
    logic out;
    logic jmp;
    logic alu;
    logic brc;
    logic brz;
  } cls_t;

  state_e state_q, state_d;
  cls_t   cls_q, cls_d;
  cls_t   dec_cls;
  cls_t   cls_act;
  logic   illegal;

  logic mem_req_c, mem_we_c, ir_load_c, pc_inc_c, pc_load_c;
  logic acc_load_c, flags_load_c, ill_c, retire_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Any set bit above the 4-bit ISA field marks the opcode illegal
  assign illegal = (op_i >> 4) != '0;

  always_comb begin
    dec_cls = '0;
    case (op_i[3:0])
      4'h0:    dec_cls.mr  = 1'b1;
      4'h1:    dec_cls.imm = 1'b1;
      4'h2:    dec_cls.mw  = 1'b1;
      4'h3:    dec_cls.inp = 1'b1;
      4'h4:    dec_cls.out = 1'b1;
      4'h5:    begin dec_cls.jmp = 1'b1; dec_cls.brc = 1'b1; end
      4'h6:    begin dec_cls.jmp = 1'b1; dec_cls.brz = 1'b1; end
      4'h7:    dec_cls.jmp = 1'b1;
      default: dec_cls.alu = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_load_c    = 1'b0;
    pc_inc_c     = 1'b0;
    pc_load_c    = 1'b0;
    acc_load_c   = 1'b0;
    flags_load_c = 1'b0;
    ill_c        = 1'b0;
    retire_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        cls_d     = '0;
        if (mem_ack_i) begin
          ir_load_c = 1'b1;
          pc_inc_c  = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          ill_c   = 1'b1;
          cls_d   = '0;
          state_d = S_FETCH;
        end else begin
          cls_d = dec_cls;
          if (dec_cls.mr || dec_cls.mw)        state_d = S_MEM;
          else if (dec_cls.inp || dec_cls.out) state_d = S_IO;
          else                                 state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_load_c   = cls_q.alu | cls_q.imm;
        flags_load_c = cls_q.alu;
        if (cls_q.jmp)
          pc_load_c = cls_q.brc ? carry_i : (cls_q.brz ? zero_i : 1'b1);
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = cls_q.mw;
        if (mem_ack_i) begin
          acc_load_c = cls_q.mr;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_IO: begin
        if (cls_q.inp) begin
          if (inp_valid_i) begin
            acc_load_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (out_ready_i) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Class selects are only presented while an instruction is executing
  assign cls_act = (state_q == S_EXEC || state_q == S_MEM || state_q == S_IO) ? cls_q : '0;

  assign mem_req_o    = rst_i ? 1'b0 : mem_req_c;
  assign mem_we_o     = rst_i ? 1'b0 : mem_we_c;
  assign ir_load_o    = rst_i ? 1'b0 : ir_load_c;
  assign pc_inc_o     = rst_i ? 1'b0 : pc_inc_c;
  assign pc_load_o    = rst_i ? 1'b0 : pc_load_c;
  assign acc_load_o   = rst_i ? 1'b0 : acc_load_c;
  assign flags_load_o = rst_i ? 1'b0 : flags_load_c;
  assign ill_o        = rst_i ? 1'b0 : ill_c;
  assign imm_o        = rst_i ? 1'b0 : cls_act.imm;
  assign mr_o         = rst_i ? 1'b0 : cls_act.mr;
  assign mw_o         = rst_i ? 1'b0 : cls_act.mw;
  assign inp_o        = rst_i ? 1'b0 : cls_act.inp;
  assign out_o        = rst_i ? 1'b0 : cls_act.out;
  assign jmp_o        = rst_i ? 1'b0 : cls_act.jmp;
  assign alu_o        = rst_i ? 1'b0 : cls_act.alu;
  assign state_o      = rst_i ? 3'd0 : state_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retire_cnt_o = rst_i ? '0 : cnt_q;
`endif

endmodule
